// File: rtl/regsr_serial_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : regsr_serial_reader_if
//  Description : Bus bundle between the set/reset register bank / host side
//                and the serial reader.
//                master modport : the side that requests frames and owns the bank
//                slave  modport : the serial reader itself
//  Signals     : start, reg_data     -> reader
//                busy, ser_frame, ser_data, ser_valid, done, clr <- reader
//  Revision    : 1.0  initial release
// ============================================================================
interface regsr_serial_reader_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int N = WIDTH * NUM_REGS;

  logic         start;
  logic [N-1:0] reg_data;
  logic         busy;
  logic         ser_frame;
  logic         ser_data;
  logic         ser_valid;
  logic         done;
  logic [N-1:0] clr;

  modport master (
    output start, reg_data,
    input  busy, ser_frame, ser_data, ser_valid, done, clr
  );

  modport slave (
    input  start, reg_data,
    output busy, ser_frame, ser_data, ser_valid, done, clr
  );
endinterface
`default_nettype wire

// File: rtl/regsr_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regsr_serial_reader
//  Description : Read side of the set/reset register bank. A start request
//                snapshots all NUM_REGS x WIDTH bank bits into a shadow shift
//                register, which is then streamed MSB-first as a framed serial
//                stream (CLK_DIV clocks per bit) while the bank keeps running.
//  Ports       : clk          single clock, posedge
//                global_reset synchronous, active-high
//                bus (slave)  start, reg_data in; busy, ser_frame, ser_data,
//                             ser_valid, done (registered), clr out
//  Config      : CLEAR_ON_READ_EN - when defined, clr pulses reg_data
//                (combinationally) in the capture cycle so the bank clears
//                exactly the bits that were reported; otherwise clr = 0.
//  Parameters  : WIDTH, NUM_REGS, CLK_DIV (>= 1)
//  Revision    : 1.0  initial release
// ============================================================================
module regsr_serial_reader #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int CLK_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  global_reset,
  regsr_serial_reader_if.slave  bus
);

  localparam int N     = WIDTH * NUM_REGS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       shadow_q, shadow_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               busy_q, busy_d;
  logic               frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  // Next-state / next-output logic. Outputs are computed one cycle ahead so
  // that every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    bit_d    = bit_q;
    busy_d   = 1'b0;
    frame_d  = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SHIFT;
          shadow_d = bus.reg_data;
          div_d    = '0;
          bit_d    = '0;
          busy_d   = 1'b1;
          frame_d  = 1'b1;
          valid_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        busy_d  = 1'b1;
        frame_d = 1'b1;
        if (div_q == C_DIV_LAST) begin
          // Bit period ends: expose the next bit at the shadow MSB. After the
          // last shift the shadow is all zeros, which keeps ser_data low in DONE.
          div_d    = '0;
          shadow_d = {shadow_q[N-2:0], 1'b0};
          if (bit_q == C_BIT_LAST) begin
            state_d = ST_DONE;
            frame_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        bit_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      frame_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ser_frame = frame_q;
  assign bus.ser_data  = shadow_q[N-1];
  assign bus.ser_valid = valid_q;
  assign bus.done      = done_q;

`ifdef CLEAR_ON_READ_EN
  // Clear exactly what is captured this cycle; a bit being set while still 0
  // sees clr=0, so it survives and is reported in the next frame.
  assign bus.clr = ((state_q == ST_IDLE) && bus.start && !global_reset) ? bus.reg_data : '0;
`else
  assign bus.clr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regsr_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regsr_serial_reader
//  Description : Bench for regsr_serial_reader. Two instances (CLK_DIV=2 and
//                CLK_DIV=1) receive identical stimulus; each is compared every
//                cycle against a frame-timing model computed from the capture
//                cycle with plain arithmetic. A small set/reset bank model is
//                attached for the clear-on-read scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regsr_serial_reader;

  localparam int WIDTH    = 8;
  localparam int NUM_REGS = 2;
  localparam int N        = WIDTH * NUM_REGS;

  logic clk;
  logic global_reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regsr_serial_reader_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus2 ();
  regsr_serial_reader_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus1 ();

  regsr_serial_reader #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .CLK_DIV(2)) dut2 (
    .clk          (clk),
    .global_reset (global_reset),
    .bus          (bus2)
  );

  regsr_serial_reader #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .CLK_DIV(1)) dut1 (
    .clk          (clk),
    .global_reset (global_reset),
    .bus          (bus1)
  );

  int total;
  int bad;
  int cyc;
  int div_of [2];

  // Model: a frame is fully described by its capture cycle and snapshot.
  bit           act_m  [2];
  int           k_m    [2];
  logic [N-1:0] snap_m [2];

  // Observed-frame bookkeeping for literal checks.
  logic [N-1:0] cap        [2];
  int           nstr       [2];
  logic [N-1:0] last_frame [2];
  int           last_nstr  [2];
  int           ndone      [2];
  int           done1      [2];
  int           done2      [2];

  bit           bank_mode;
  logic [N-1:0] bank;
  logic [N-1:0] clr_seen0;

  task automatic chk(input string name, input int i, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s div%0d cyc=%0d got=%h want=%h", name, div_of[i], cyc, act, exp);
    end
  endtask

  function automatic void model_out(input int i, input int c,
                                    output logic b, output logic f, output logic d,
                                    output logic v, output logic dn);
    int t;
    int dv;
    int j;
    dv = div_of[i];
    b = 1'b0; f = 1'b0; d = 1'b0; v = 1'b0; dn = 1'b0;
    if (act_m[i]) begin
      t = c - k_m[i];
      if (t >= 1 && t <= N * dv) begin
        j = (t - 1) / dv;
        b = 1'b1;
        f = 1'b1;
        d = snap_m[i][N-1-j];
        v = (((t - 1) % dv) == 0);
      end else if (t == N * dv + 1) begin
        b  = 1'b1;
        dn = 1'b1;
      end
    end
  endfunction

  function automatic bit model_idle(input int i, input int c);
    return !act_m[i] || ((c - k_m[i]) > N * div_of[i] + 1);
  endfunction

  function automatic void dut_out(input int i,
                                  output logic b, output logic f, output logic d,
                                  output logic v, output logic dn, output logic [N-1:0] cl);
    if (i == 0) begin
      b = bus2.busy; f = bus2.ser_frame; d = bus2.ser_data;
      v = bus2.ser_valid; dn = bus2.done; cl = bus2.clr;
    end else begin
      b = bus1.busy; f = bus1.ser_frame; d = bus1.ser_data;
      v = bus1.ser_valid; dn = bus1.done; cl = bus1.clr;
    end
  endfunction

  // One clock cycle: drive inputs, check outputs of this cycle, advance the
  // model over the coming edge, then move to the next cycle.
  task automatic step(input logic s, input logic [N-1:0] d_in, input logic r, input logic [N-1:0] setv);
    logic [N-1:0] d;
    logic [N-1:0] ecl;
    logic [N-1:0] ecl0;
    logic [N-1:0] acl;
    logic eb, ef, ed, ev, edn;
    logic ab, af, ad, av, adn;
    d = bank_mode ? bank : d_in;
    global_reset  = r;
    bus2.start    = s;
    bus1.start    = s;
    bus2.reg_data = d;
    bus1.reg_data = d;
    #1;
    ecl0 = '0;
    for (int i = 0; i < 2; i++) begin
      model_out(i, cyc, eb, ef, ed, ev, edn);
      dut_out(i, ab, af, ad, av, adn, acl);
`ifdef CLEAR_ON_READ_EN
      ecl = (model_idle(i, cyc) && s && !r) ? d : '0;
`else
      ecl = '0;
`endif
      if (i == 0) ecl0 = ecl;
      chk("busy",      i, N'(ab),  N'(eb));
      chk("ser_frame", i, N'(af),  N'(ef));
      chk("ser_data",  i, N'(ad),  N'(ed));
      chk("ser_valid", i, N'(av),  N'(ev));
      chk("done",      i, N'(adn), N'(edn));
      chk("clr",       i, acl,     ecl);
      if (i == 0 && cyc == 0) clr_seen0 = acl;
      if (av === 1'b1) begin
        cap[i] = {cap[i][N-2:0], ad};
        nstr[i]++;
      end
      if (adn === 1'b1) begin
        last_frame[i] = cap[i];
        last_nstr[i]  = nstr[i];
        ndone[i]++;
        if (ndone[i] == 1) done1[i] = cyc;
        else if (ndone[i] == 2) done2[i] = cyc;
        cap[i]  = '0;
        nstr[i] = 0;
      end
      if (r) begin
        cap[i]  = '0;
        nstr[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        act_m[i] = 1'b0;
      end else if (model_idle(i, cyc) && s) begin
        act_m[i]  = 1'b1;
        k_m[i]    = cyc;
        snap_m[i] = d;
      end
    end
    // Bank bit: reset dominates set, matching the Bit cell.
    if (bank_mode) bank = (bank | setv) & ~ecl0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart();
    step(1'b0, '0, 1'b1, '0);
    step(1'b0, '0, 1'b1, '0);
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      ndone[i] = 0; done1[i] = -1; done2[i] = -1;
      nstr[i] = 0; cap[i] = '0; last_frame[i] = '0; last_nstr[i] = 0;
    end
  endtask

  initial begin
    logic mb, mf, md, mv, mdn;
    total = 0;
    bad = 0;
    cyc = 0;
    div_of[0] = 2;
    div_of[1] = 1;
    bank_mode = 1'b0;
    bank = '0;
    clr_seen0 = '0;
    for (int i = 0; i < 2; i++) begin
      act_m[i] = 1'b0; k_m[i] = 0; snap_m[i] = '0;
    end

    global_reset  = 1'b1;
    bus2.start    = 1'b0;
    bus1.start    = 1'b0;
    bus2.reg_data = '0;
    bus1.reg_data = '0;
    @(posedge clk);
    #1;
    chk("rst_outputs", 0, N'({bus2.busy, bus2.ser_frame, bus2.ser_data, bus2.ser_valid, bus2.done}), '0);
    chk("rst_clr",     0, bus2.clr, '0);

    // Basic frame 16'hA55A.
    restart();
    step(1'b1, 16'hA55A, 1'b0, '0);
    model_out(0, 33, mb, mf, md, mv, mdn);
    chk("model_done33", 0, N'(mdn), N'(1'b1));
    model_out(0, 2, mb, mf, md, mv, mdn);
    chk("model_c2", 0, N'({md, mv}), N'(2'b10));
    model_out(0, 3, mb, mf, md, mv, mdn);
    chk("model_c3", 0, N'({md, mv}), N'(2'b01));
    model_out(1, 16, mb, mf, md, mv, mdn);
    chk("model_d1_c16", 1, N'({md, mv}), N'(2'b01));
    repeat (34) step(1'b0, 16'hA55A, 1'b0, '0);
    chk("t1_frame",   0, last_frame[0], 16'hA55A);
    chk("t1_strobes", 0, N'(last_nstr[0]), N'(16));
    chk("t1_done_at", 0, N'(done1[0]), N'(33));
    chk("t1_done_at", 1, N'(done1[1]), N'(17));

    // Data change and start while busy are ignored.
    restart();
    step(1'b1, 16'hA55A, 1'b0, '0);
    repeat (9) step(1'b0, 16'hA55A, 1'b0, '0);
    step(1'b1, 16'hFFFF, 1'b0, '0);
    repeat (30) step(1'b0, 16'hFFFF, 1'b0, '0);
    chk("t2_frame",  0, last_frame[0], 16'hA55A);
    chk("t2_ndone",  0, N'(ndone[0]), N'(1));
    chk("t2_frame",  1, last_frame[1], 16'hA55A);
    chk("t2_ndone",  1, N'(ndone[1]), N'(1));

    // start held high: back-to-back frames at minimum spacing.
    restart();
    repeat (70) step(1'b1, 16'hA55A, 1'b0, '0);
    chk("t3_done1", 0, N'(done1[0]), N'(33));
    chk("t3_done2", 0, N'(done2[0]), N'(67));
    chk("t3_done1", 1, N'(done1[1]), N'(17));
    chk("t3_done2", 1, N'(done2[1]), N'(35));

    // Mid-frame reset aborts; later frame is clean.
    restart();
    step(1'b1, 16'h3C96, 1'b0, '0);
    repeat (11) step(1'b0, 16'h3C96, 1'b0, '0);
    step(1'b0, 16'h3C96, 1'b1, '0);
    chk("t4_abort", 0, N'({bus2.busy, bus2.ser_frame, bus2.ser_data, bus2.ser_valid, bus2.done}), '0);
    repeat (7) step(1'b0, 16'h3C96, 1'b0, '0);
    step(1'b1, 16'h3C96, 1'b0, '0);
    repeat (40) step(1'b0, 16'h3C96, 1'b0, '0);
    chk("t4_ndone",  0, N'(ndone[0]), N'(1));
    chk("t4_done_at", 0, N'(done1[0]), N'(53));
    chk("t4_frame",  0, last_frame[0], 16'h3C96);
    chk("t4_done_at", 1, N'(done1[1]), N'(37));

    // Single-cycle bit periods.
    restart();
    step(1'b1, 16'h8001, 1'b0, '0);
    repeat (40) step(1'b0, 16'h8001, 1'b0, '0);
    chk("t5_frame",   1, last_frame[1], 16'h8001);
    chk("t5_strobes", 1, N'(last_nstr[1]), N'(16));
    chk("t5_done_at", 1, N'(done1[1]), N'(17));

    // Bank attached: bits 3 and 9 set, bit 4 set during capture.
    restart();
    bank_mode = 1'b1;
    bank = 16'h0208;
    step(1'b1, '0, 1'b0, 16'h0010);
    repeat (35) step(1'b0, '0, 1'b0, '0);
    chk("t6_frame1", 0, last_frame[0], 16'h0208);
`ifdef CLEAR_ON_READ_EN
    chk("t6_clr0",  0, clr_seen0, 16'h0208);
    chk("t6_bank",  0, bank, 16'h0010);
`else
    chk("t6_clr0",  0, clr_seen0, 16'h0000);
    chk("t6_bank",  0, bank, 16'h0218);
`endif
    step(1'b1, '0, 1'b0, '0);
    repeat (35) step(1'b0, '0, 1'b0, '0);
`ifdef CLEAR_ON_READ_EN
    chk("t6_frame2", 0, last_frame[0], 16'h0010);
`else
    chk("t6_frame2", 0, last_frame[0], 16'h0218);
`endif
    bank_mode = 1'b0;

    // Randomized traffic with occasional resets.
    restart();
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] rd;
      rd = N'($urandom);
      step(($urandom % 6) == 0, rd, ($urandom % 150) == 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
